// File: rtl/systolic_writeback_pkg.sv
// Shared constants and state encoding for the systolic array writeback path.
package systolic_writeback_pkg;

  localparam int unsigned ARRAY_SIZE      = 32;
  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned OUTCOME_WIDTH   = 21;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH      = 10;

  localparam int unsigned LANES_PER_WORD  = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned NUM_BANKS       = ARRAY_SIZE / LANES_PER_WORD;
  localparam int unsigned IDX_WIDTH       = 6;
  localparam int unsigned K_WIDTH         = 5;
  localparam int unsigned SHIFT_WIDTH     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/systolic_writeback_requant_lane.sv
// One lane of requantization: rounding arithmetic shift, optional ReLU, int8 saturation.
module requant_lane
  import systolic_writeback_pkg::*;
(
  input  logic [OUTCOME_WIDTH-1:0] x_i,
  input  logic [SHIFT_WIDTH-1:0]   shift_i,
  input  logic                     relu_i,
  output logic [DATA_WIDTH-1:0]    q_c_o
);

  localparam int unsigned EXT_WIDTH = OUTCOME_WIDTH + 1;
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = 127;
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = -128;

  logic signed [EXT_WIDTH-1:0] x_s;
  logic signed [EXT_WIDTH-1:0] rnd_s;
  logic signed [EXT_WIDTH-1:0] sum_s;
  logic signed [EXT_WIDTH-1:0] y_s;
  logic signed [EXT_WIDTH-1:0] z_s;

  // Extra headroom bit keeps x + 2^(shift-1) from overflowing.
  always_comb begin
    x_s   = $signed({x_i[OUTCOME_WIDTH-1], x_i});
    rnd_s = $signed(EXT_WIDTH'(1) << (shift_i - 4'd1));
    sum_s = x_s + rnd_s;
    if (shift_i == 4'd0) y_s = x_s;
    else                 y_s = sum_s >>> shift_i;
    if (relu_i && (y_s < 0)) z_s = '0;
    else                     z_s = y_s;
    if (z_s > SAT_MAX)      q_c_o = 8'h7F;
    else if (z_s < SAT_MIN) q_c_o = 8'h80;
    else                    q_c_o = z_s[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_writeback.sv
// Sweeps the array diagonals, requantizes all lanes and writes them to the 8 SRAM banks.
module systolic_writeback
  import systolic_writeback_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [SHIFT_WIDTH-1:0]              quant_shift,
  input  logic                                relu_en,
  input  logic                                sram_busy,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic [IDX_WIDTH-1:0]                matrix_index,
  output logic                                sram_wen,
  output logic [ADDR_WIDTH-1:0]               sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_0,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_1,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_2,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_3,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_4,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_5,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_6,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata_7,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LANE_BITS = ARRAY_SIZE * OUTCOME_WIDTH;
  localparam int unsigned WORD_BITS = NUM_BANKS * SRAM_DATA_WIDTH;

  logic [1:0]             state_q,  state_d;
  logic [IDX_WIDTH-1:0]   idx_q,    idx_d;
  logic                   v1_q,     v1_d;
  logic [K_WIDTH-1:0]     k1_q,     k1_d;
  logic [LANE_BITS-1:0]   lanes_q,  lanes_d;
  logic [ADDR_WIDTH-1:0]  base_q,   base_d;
  logic [SHIFT_WIDTH-1:0] shift_q,  shift_d;
  logic                   relu_q,   relu_d;
  logic                   wen_q,    wen_d;
  logic [ADDR_WIDTH-1:0]  waddr_q,  waddr_d;
  logic [WORD_BITS-1:0]   wdata_q,  wdata_d;
  logic                   busy_q,   busy_d;
  logic                   done_q,   done_d;

  logic [ARRAY_SIZE*DATA_WIDTH-1:0] quant_c;
  logic [WORD_BITS-1:0]             packed_c;

  // Requantize every captured lane in parallel.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    requant_lane u_lane (
      .x_i     (lanes_q[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .q_c_o   (quant_c[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Lowest lane of each group of four lands in the most significant byte.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar m = 0; m < LANES_PER_WORD; m++) begin : g_byte
      assign packed_c[b*SRAM_DATA_WIDTH + (SRAM_DATA_WIDTH-1-DATA_WIDTH*m) -: DATA_WIDTH] =
        quant_c[(b*LANES_PER_WORD+m)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, pipeline advance and output decode; sram_busy freezes everything but IDLE/DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    v1_d    = v1_q;
    k1_d    = k1_q;
    lanes_d = lanes_q;
    base_d  = base_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    wen_d   = 1'b1;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (!sram_busy) begin
      v1_d = 1'b0;
      if (v1_q) begin
        wen_d   = 1'b0;
        waddr_d = base_q + ADDR_WIDTH'(k1_q);
        wdata_d = packed_c;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          base_d  = base_addr;
          shift_d = quant_shift;
          relu_d  = relu_en;
        end
      end
      ST_RUN: begin
        if (!sram_busy) begin
          v1_d    = 1'b1;
          k1_d    = idx_q[K_WIDTH-1:0];
          lanes_d = mul_outcome;
          if (idx_q == IDX_WIDTH'(ARRAY_SIZE-1)) state_d = ST_DRAIN;
          else                                    idx_d   = idx_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        // The last write leaves S2 on this edge once S1 is already empty.
        if (!sram_busy && !v1_q) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      v1_q    <= 1'b0;
      k1_q    <= '0;
      lanes_q <= '0;
      base_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      wen_q   <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v1_q    <= v1_d;
      k1_q    <= k1_d;
      lanes_q <= lanes_d;
      base_q  <= base_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign matrix_index = idx_q;
  assign sram_wen     = wen_q;
  assign sram_waddr   = waddr_q;
  assign sram_wdata_0 = wdata_q[0*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_1 = wdata_q[1*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_2 = wdata_q[2*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_3 = wdata_q[3*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_4 = wdata_q[4*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_5 = wdata_q[5*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_6 = wdata_q[6*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign sram_wdata_7 = wdata_q[7*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback: quantization vector table plus sweep corner cases.
module tb_systolic_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [3:0]  quant_shift;
  logic        relu_en;
  logic        sram_busy;
  logic [671:0] mul_outcome;
  logic [5:0]  matrix_index;
  logic        sram_wen;
  logic [9:0]  sram_waddr;
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic        busy;
  logic        done;

  systolic_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .quant_shift(quant_shift), .relu_en(relu_en), .sram_busy(sram_busy),
    .mul_outcome(mul_outcome), .matrix_index(matrix_index), .sram_wen(sram_wen),
    .sram_waddr(sram_waddr), .sram_wdata_0(w0), .sram_wdata_1(w1), .sram_wdata_2(w2),
    .sram_wdata_3(w3), .sram_wdata_4(w4), .sram_wdata_5(w5), .sram_wdata_6(w6),
    .sram_wdata_7(w7), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         x;
    logic [3:0] sh;
    logic       relu;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  int errors = 0;
  int checks = 0;

  // Sweep context read by the array model and the write monitor.
  int          cur_mode = 0;   // 0: lane=k, 1: lane=cur_val, 2: lane=i+k
  logic [20:0] cur_val  = '0;
  logic [7:0]  cur_exp  = '0;
  logic [9:0]  cur_base = '0;
  int wr_cnt = 0, done_cnt = 0;
  int first_cyc = 0, last_cyc = 0, done_cyc = 0, accept_cyc = 0;
  logic [9:0] addr16 = '0;

  // Array model: combinational from matrix_index.
  always_comb begin
    mul_outcome = '0;
    for (int i = 0; i < 32; i++) begin
      if (cur_mode == 0)      mul_outcome[i*21 +: 21] = 21'(matrix_index);
      else if (cur_mode == 1) mul_outcome[i*21 +: 21] = cur_val;
      else                    mul_outcome[i*21 +: 21] = 21'(i) + 21'(matrix_index);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input int k);
    logic [255:0] d;
    logic [7:0] bv;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      for (int m = 0; m < 4; m++) begin
        if (cur_mode == 0)      bv = 8'(k);
        else if (cur_mode == 1) bv = cur_exp;
        else                    bv = 8'(4*b + m + k);
        d[b*32 + 31 - 8*m -: 8] = bv;
      end
    end
    return d;
  endfunction

  // Checks every write against the expected address/data sequence.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && !sram_wen) begin
        if (wr_cnt >= 32) begin
          chk("extra_write", 256'(wr_cnt), 256'd31);
        end else begin
          chk("write_addr", 256'(sram_waddr), 256'(10'(cur_base + 10'(wr_cnt))));
          chk("write_data", {w7, w6, w5, w4, w3, w2, w1, w0}, exp_data(wr_cnt));
        end
        if (wr_cnt == 0)  first_cyc = cyc;
        if (wr_cnt == 16) addr16 = sram_waddr;
        last_cyc = cyc;
        wr_cnt++;
      end
      if (rst_n && done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic start_sweep(input logic [9:0] b, input logic [3:0] sh, input logic r,
                             input int mode, input logic [20:0] val, input logic [7:0] e);
    @(negedge clk);
    cur_mode = mode; cur_val = val; cur_exp = e; cur_base = b;
    wr_cnt = 0; done_cnt = 0;
    base_addr = b; quant_shift = sh; relu_en = r; start = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_cnt < n && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (wr_cnt < n) chk("wait_writes_timeout", 256'(wr_cnt), 256'(n));
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) chk({name, "_done_timeout"}, 256'(done_cnt), 256'd1);
    repeat (4) @(negedge clk);
    chk({name, "_write_count"}, 256'(wr_cnt), 256'd32);
    chk({name, "_done_count"}, 256'(done_cnt), 256'd1);
  endtask

  initial begin
    logic [5:0] held_idx;
    int snap;

    vecs[0]  = '{300,      4'd1,  1'b0, 8'h7F};
    vecs[1]  = '{-1000,    4'd3,  1'b0, 8'h83};
    vecs[2]  = '{5,        4'd1,  1'b0, 8'h03};
    vecs[3]  = '{-5,       4'd0,  1'b1, 8'h00};
    vecs[4]  = '{-5,       4'd1,  1'b0, 8'hFE};
    vecs[5]  = '{-300,     4'd0,  1'b0, 8'h80};
    vecs[6]  = '{128,      4'd0,  1'b0, 8'h7F};
    vecs[7]  = '{1048575,  4'd15, 1'b0, 8'h20};
    vecs[8]  = '{-1048576, 4'd15, 1'b0, 8'hE0};
    vecs[9]  = '{3,        4'd2,  1'b1, 8'h01};
    vecs[10] = '{-129,     4'd0,  1'b0, 8'h80};
    vecs[11] = '{252,      4'd1,  1'b0, 8'h7E};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; quant_shift = '0;
    relu_en = 1'b0; sram_busy = 1'b0;

    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_wen",   256'(sram_wen),     256'd1);
    chk("rst_waddr", 256'(sram_waddr),   256'd0);
    chk("rst_wdata", {w7, w6, w5, w4, w3, w2, w1, w0}, 256'd0);
    chk("rst_busy",  256'(busy),         256'd0);
    chk("rst_done",  256'(done),         256'd0);
    chk("rst_index", 256'(matrix_index), 256'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic sweep with identity quantization and latency checks.
    start_sweep(10'h100, 4'd0, 1'b0, 0, '0, '0);
    chk("busy_after_start", 256'(busy), 256'd1);
    wait_done("basic");
    chk("first_write_latency", 256'(first_cyc), 256'(accept_cyc + 2));
    chk("done_after_last",     256'(done_cyc),  256'(last_cyc + 1));
    chk("idle_busy",           256'(busy),      256'd0);

    // Distinct value per lane exposes byte packing order.
    start_sweep(10'h000, 4'd0, 1'b0, 2, '0, '0);
    wait_done("packing");

    // Quantization vector table.
    for (int v = 0; v < 12; v++) begin
      start_sweep(10'(v * 64), vecs[v].sh, vecs[v].relu, 1, 21'(vecs[v].x), vecs[v].exp);
      wait_done($sformatf("vec%0d", v));
    end

    // Backpressure for three cycles just before write 10.
    start_sweep(10'h080, 4'd0, 1'b0, 0, '0, '0);
    wait_writes(10);
    held_idx = matrix_index;
    sram_busy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk("stall_wen",   256'(sram_wen),     256'd1);
      chk("stall_index", 256'(matrix_index), 256'(held_idx));
      chk("stall_count", 256'(wr_cnt),       256'd10);
    end
    @(negedge clk);
    sram_busy = 1'b0;
    wait_done("stall");

    // Start pulses during RUN and in the DONE cycle are ignored.
    start_sweep(10'h180, 4'd0, 1'b0, 0, '0, '0);
    wait_writes(5);
    start = 1'b1; base_addr = 10'h2AA;
    @(negedge clk);
    start = 1'b0;
    begin
      int t = 0;
      while (done_cnt == 0 && t < 300) begin
        @(negedge clk); #1;
        t++;
      end
    end
    chk("done_seen", 256'(done_cnt), 256'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("ignored_start_writes", 256'(wr_cnt),   256'd32);
    chk("ignored_start_done",   256'(done_cnt), 256'd1);
    chk("ignored_start_busy",   256'(busy),     256'd0);

    // Reset in the middle of a sweep.
    start_sweep(10'h040, 4'd0, 1'b0, 0, '0, '0);
    wait_writes(18);
    rst_n = 1'b0;
    #1;
    chk("midrst_wen",   256'(sram_wen),     256'd1);
    chk("midrst_waddr", 256'(sram_waddr),   256'd0);
    chk("midrst_wdata", {w7, w6, w5, w4, w3, w2, w1, w0}, 256'd0);
    chk("midrst_busy",  256'(busy),         256'd0);
    chk("midrst_done",  256'(done),         256'd0);
    chk("midrst_index", 256'(matrix_index), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = wr_cnt;
    repeat (20) @(negedge clk);
    chk("midrst_no_writes", 256'(wr_cnt),   256'(snap));
    chk("midrst_no_done",   256'(done_cnt), 256'd0);
    start_sweep(10'h200, 4'd0, 1'b0, 0, '0, '0);
    wait_done("after_reset");

    // Address wrap at the top of the address space.
    start_sweep(10'h3F0, 4'd0, 1'b0, 0, '0, '0);
    wait_done("wrap");
    chk("wrap_addr16", 256'(addr16), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_writeback.md
Name: systolic_writeback

Overview:
- Drains a finished 32x32 result matrix from the systolic array and writes it to the output SRAM banks as requantized 8-bit data.
- Sweeps `matrix_index` and captures the 32 lanes of `mul_outcome` for each index. Lanes are requantized with rounding shift, optional ReLU and saturation, then packed into eight 32-bit words.
- Sits downstream of the systolic array and is the write-side counterpart of its SRAM read interface.

Parameters:
- ARRAY_SIZE, 32, lanes per wrapped diagonal and number of indices swept.
- DATA_WIDTH, 8, width of a packed output element.
- OUTCOME_WIDTH, 21, signed width of one `mul_outcome` lane.
- SRAM_DATA_WIDTH, 32, width of one bank word (4 elements).
- ADDR_WIDTH, 10, SRAM write address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  first write address; sampled on accepted start
- quant_shift  in  4  arithmetic right shift (0..15); sampled on accepted start
- relu_en  in  1  clamp negatives to 0; sampled on accepted start
- sram_busy  in  1  backpressure; while 1, the whole pipeline freezes
- mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  array output for the current `matrix_index`; lane i at [i*21 +: 21]
- matrix_index  out  6  registered diagonal select driven to the array
- sram_wen  out  1  active-low write enable, shared by all 8 banks
- sram_waddr  out  ADDR_WIDTH  shared write address
- sram_wdata_0..sram_wdata_7  out  32 each  packed write data per bank
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the final write has completed

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, matrix_index=0, sram_wen=1, sram_waddr=0, all sram_wdata=0, busy=0, done=0.
  - All pipeline valids cleared; sampled config registers cleared.
  - Reset mid-sweep aborts it: no further writes and no done pulse.
- Lane mapping: at index k (0..31), lane i holds C[i][(k-i) mod 32]. Indices 0..31 therefore cover the matrix exactly once and indices 32..63 are never issued.
- FSM:
  - IDLE: on start, latch config, matrix_index<=0, go to RUN. Start is ignored in every other state.
  - RUN: each unstalled cycle issues index k. After issuing k=31, go to DRAIN.
  - DRAIN: wait for both pipeline valids to empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- Pipeline (all stages advance only when sram_busy=0):
  - S0: matrix_index=k is registered; `mul_outcome` is combinational from it.
  - S1: capture all 32 lanes of `mul_outcome` together with v1.
  - S2: quantize the captured lanes and register the write; sram_wen=0, sram_waddr=base_addr+k.
  - Latency: index k driven at cycle t produces its write at cycle t+2 with no stall, t+2+stall_cycles with stalls.
  - sram_wen is low exactly one cycle per write. It is held high while sram_busy=1, and the write is re-presented on the first unstalled cycle.
- Quantize, per lane, in 22-bit signed arithmetic:
  - If shift=0: y=x. Otherwise y=(x + 2^(shift-1)) >>> shift (round half up).
  - If relu_en and y<0: y=0.
  - Saturate y to [-128, 127].
- Packing: lane 4b+m goes to sram_wdata_b[31-8m -: 8], i.e. MSB byte first (same order as the read side).
- Address wrap: base_addr+k wraps modulo 2^ADDR_WIDTH.
- Exactly 32 writes occur per start.

Decomposition:
- Shared package: ARRAY_SIZE, DATA_WIDTH, OUTCOME_WIDTH, SRAM_DATA_WIDTH, state encoding (IDLE/RUN/DRAIN/DONE).
- Sub-module `requant_lane`: combinational 21-bit to 8-bit rounding shift, ReLU and saturate. Instantiated 32 times.

Test Plan:
- Reset, then start with base_addr=0x100, shift=0, relu=0, and every lane of `mul_outcome` = k -> 32 writes at addresses 0x100..0x11F. Write k has all bytes = k. done fires 1 cycle after the last write, and the first write occurs 2 cycles after matrix_index=0.
- Lane value 300 with shift=1 -> 150, saturated to 0x7F. Value -1000 with shift=3 -> -125 = 0x83. Value 5 with shift=1 -> 3 (round half up). Value -5 with relu=1 and shift=0 -> 0x00.
- Assert sram_busy for 3 cycles at write k=10 -> matrix_index holds, sram_wen stays high, and write 10 appears once after release. The total write count is still 32.
- Pulse start during RUN and during DONE -> ignored: exactly one sweep of 32 writes, one done pulse.
- Deassert rst_n at write k=17 -> outputs return to reset values immediately, with no done pulse. A new start then performs a full 32-write sweep from base_addr.
- base_addr=0x3F0 with ADDR_WIDTH=10 -> the address wraps from 0x3FF to 0x000 at k=16.
